// File: rtl/tx_scrambler_pkg.sv
// Shared constants and types for the per-lane TX scrambler.
package tx_scrambler_pkg;

  localparam logic [7:0] COM       = 8'hBC;
  localparam logic [7:0] SKP       = 8'h1C;
  localparam logic [7:0] SKPOS_SYM = 8'hAA;
  localparam logic [7:0] EIEOS_SYM = 8'h00;
  localparam logic [1:0] SH_DATA   = 2'b10;
  localparam logic [1:0] SH_OS     = 2'b01;

  // Galois feedback masks (x^N term implied by the shifted-out bit)
  localparam logic [15:0] POLY16 = 16'h0039;
  localparam logic [22:0] POLY23 = 23'h210125;

  localparam logic [23:0] LANE_SEED [8] = '{
    24'h1DBFBC, 24'h0607BB, 24'h1EC760, 24'h18C0DB,
    24'h010F12, 24'h19CFC9, 24'h0277CE, 24'h1BB807
  };

  typedef enum logic [1:0] {
    BLK_DATA,
    BLK_SKPOS,
    BLK_EIEOS,
    BLK_OTHEROS
  } blk_t;

endpackage

// File: rtl/tx_lane_scrambler_lfsr_byte_step.sv
// One symbol of LFSR stepping: 8 serial Galois steps, optional XOR of the
// output bit into the byte (LSB first).
module lfsr_byte_step
  import tx_scrambler_pkg::*;
(
  input  logic [22:0] i_lfsr,
  input  logic [7:0]  i_byte,
  input  logic        i_mode,  // 1: 23-bit Gen3 LFSR, 0: 16-bit Gen1/2 LFSR
  input  logic        i_adv,
  input  logic        i_scr,
  output logic [22:0] o_lfsr,
  output logic [7:0]  o_byte
);

  logic [22:0] w_st;
  logic        w_fb;

  always_comb begin
    w_st   = i_lfsr;
    w_fb   = 1'b0;
    o_byte = i_byte;
    for (int unsigned b = 0; b < 8; b++) begin
      w_fb = i_mode ? w_st[22] : w_st[15];
      if (i_scr) o_byte[b[2:0]] = i_byte[b[2:0]] ^ w_fb;
      if (i_mode) w_st = {w_st[21:0], 1'b0} ^ (w_fb ? POLY23 : '0);
      else        w_st = {7'd0, w_st[14:0], 1'b0} ^ {7'd0, (w_fb ? POLY16 : 16'd0)};
    end
    o_lfsr = i_adv ? w_st : i_lfsr;
  end

endmodule

// File: rtl/tx_lane_scrambler.sv
// Per-lane TX scrambler: Gen1/2 8b/10b symbol scrambling and Gen3 128b/130b
// block scrambling, one registered cycle of latency on every output.
module tx_lane_scrambler
  import tx_scrambler_pkg::*;
#(
  parameter logic [15:0] GEN12_SEED = 16'hFFFF,
  parameter int unsigned MAXWIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            GEN,
  input  logic                  turnOff,
  input  logic [5:0]            PIPEWIDTH,
  input  logic                  dataValid,
  input  logic                  startBlock,
  input  logic [1:0]            syncHeader,
  input  logic [23:0]           seedValue,
  input  logic [MAXWIDTH-1:0]   data,
  input  logic [MAXWIDTH/8-1:0] dataK,
  output logic [MAXWIDTH-1:0]   scrambledData,
  output logic [MAXWIDTH/8-1:0] scrambledDataK,
  output logic                  scrambledDataValid,
  output logic [1:0]            scrambledSyncHeader,
  output logic                  scrambledStartBlock
);

  localparam int unsigned NSYM = MAXWIDTH / 8;

  logic [15:0] r_lfsr16;
  logic [22:0] r_lfsr23;
  blk_t        r_blkType;
  logic [3:0]  r_symCnt;
  logic [2:0]  r_gen;

  logic          w_gen12, w_gen3, w_genChg;
  logic [2:0]    w_n;
  logic [15:0]   w_l16;
  logic [22:0]   w_l23, w_seedIn, w_tail;
  logic [3:0]    w_cnt, w_cntNext;
  blk_t          w_blk, w_blkNext;
  logic          w_tracked, w_eieosEnd;
  logic [MAXWIDTH-1:0] w_dataOut;
  logic [NSYM-1:0]     w_kOut;
  logic          w_unused;

  assign w_unused = ^{seedValue[23], PIPEWIDTH[2:0]};

  // A GEN change restarts both LFSRs and block tracking for this very beat.
  always_comb begin
    w_gen12  = (GEN == 3'd1) || (GEN == 3'd2);
    w_gen3   = (GEN == 3'd3);
    w_genChg = (GEN != r_gen);
    w_n      = (PIPEWIDTH[5:3] > 3'(NSYM)) ? 3'(NSYM) : PIPEWIDTH[5:3];
    w_l16    = w_genChg ? GEN12_SEED : r_lfsr16;
    w_l23    = w_genChg ? seedValue[22:0] : r_lfsr23;
    w_seedIn = w_gen3 ? w_l23 : {7'd0, w_l16};
  end

  always_comb begin
    w_cnt     = w_genChg ? 4'd0 : r_symCnt;
    w_tracked = startBlock || (w_cnt != 4'd0);
    w_blk     = r_blkType;
    if (startBlock) begin
      if (syncHeader == SH_DATA)       w_blk = BLK_DATA;
      else if (data[7:0] == SKPOS_SYM) w_blk = BLK_SKPOS;
      else if (data[7:0] == EIEOS_SYM) w_blk = BLK_EIEOS;
      else                             w_blk = BLK_OTHEROS;
    end
    w_blkNext  = r_blkType;
    w_cntNext  = w_cnt;
    w_eieosEnd = 1'b0;
    if (w_gen3 && dataValid && w_tracked) begin
      w_blkNext  = w_blk;
      w_cntNext  = (startBlock ? 4'd0 : w_cnt) + {1'b0, w_n};
      w_eieosEnd = (w_blk == BLK_EIEOS) && (w_cntNext == 4'd0);
    end
  end

  for (genvar gi = 0; gi < NSYM; gi++) begin : g_sym
    logic [7:0]  w_byte, w_byteOut;
    logic        w_k, w_act, w_scr, w_adv, w_com;
    logic [22:0] w_lin, w_lstep, w_lout;

    assign w_byte = data[8*gi +: 8];
    assign w_k    = dataK[gi];

    if (gi == 0) begin : g_head
      assign w_lin = w_seedIn;
    end else begin : g_link
      assign w_lin = g_sym[gi-1].w_lout;
    end

    always_comb begin
      w_act = dataValid && (3'(gi) < w_n);
      w_scr = 1'b0;
      w_adv = 1'b0;
      w_com = 1'b0;
      if (w_act && w_gen12) begin
        w_com = w_k && (w_byte == COM);
        w_adv = !(w_k && ((w_byte == COM) || (w_byte == SKP)));
        w_scr = !w_k && !turnOff;
      end else if (w_act && w_gen3 && w_tracked) begin
        w_adv = (w_blk != BLK_SKPOS);
        w_scr = (w_blk == BLK_DATA) && !turnOff;
      end
    end

    lfsr_byte_step u_step (
      .i_lfsr (w_lin),
      .i_byte (w_byte),
      .i_mode (w_gen3),
      .i_adv  (w_adv),
      .i_scr  (w_scr),
      .o_lfsr (w_lstep),
      .o_byte (w_byteOut)
    );

    assign w_lout                = w_com ? {7'd0, GEN12_SEED} : w_lstep;
    assign w_dataOut[8*gi +: 8]  = w_act ? w_byteOut : 8'd0;
    assign w_kOut[gi]            = w_act && w_gen12 && w_k;
  end

  assign w_tail = g_sym[NSYM-1].w_lout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scrambledData       <= '0;
      scrambledDataK      <= '0;
      scrambledDataValid  <= 1'b0;
      scrambledSyncHeader <= '0;
      scrambledStartBlock <= 1'b0;
      r_lfsr16            <= GEN12_SEED;
      r_lfsr23            <= seedValue[22:0];
      r_blkType           <= BLK_DATA;
      r_symCnt            <= '0;
      r_gen               <= '0;
    end else begin
      scrambledData       <= w_dataOut;
      scrambledDataK      <= w_kOut;
      scrambledDataValid  <= dataValid;
      scrambledSyncHeader <= syncHeader;
      scrambledStartBlock <= startBlock;
      r_gen               <= GEN;
      r_lfsr16            <= w_gen12 ? w_tail[15:0] : w_l16;
      r_lfsr23            <= w_gen3 ? (w_eieosEnd ? seedValue[22:0] : w_tail) : w_l23;
      r_blkType           <= w_blkNext;
      r_symCnt            <= w_cntNext;
    end
  end

endmodule

// File: tb/tb_tx_lane_scrambler.sv
// Self-checking bench for tx_lane_scrambler: directed golden vectors plus
// randomized Gen1/2 and Gen3 traffic against a polynomial-arithmetic model.
module tb_tx_lane_scrambler;
  import tx_scrambler_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  GEN;
  logic        turnOff;
  logic [5:0]  PIPEWIDTH;
  logic        dataValid, startBlock;
  logic [1:0]  syncHeader;
  logic [23:0] seedValue;
  logic [31:0] data;
  logic [3:0]  dataK;
  logic [31:0] scrambledData;
  logic [3:0]  scrambledDataK;
  logic        scrambledDataValid;
  logic [1:0]  scrambledSyncHeader;
  logic        scrambledStartBlock;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int T_DATA = 0, T_SKPOS = 1, T_EIEOS = 2, T_OTHER = 3;

  // model state
  logic [15:0] m16;
  logic [22:0] m23;
  logic [3:0]  m_cnt;
  int          m_type;
  logic [2:0]  m_gen;

  always #5 clk = ~clk;

  tx_lane_scrambler #(.GEN12_SEED(16'hFFFF), .MAXWIDTH(32)) dut (
    .clk(clk), .reset(reset), .GEN(GEN), .turnOff(turnOff), .PIPEWIDTH(PIPEWIDTH),
    .dataValid(dataValid), .startBlock(startBlock), .syncHeader(syncHeader),
    .seedValue(seedValue), .data(data), .dataK(dataK),
    .scrambledData(scrambledData), .scrambledDataK(scrambledDataK),
    .scrambledDataValid(scrambledDataValid), .scrambledSyncHeader(scrambledSyncHeader),
    .scrambledStartBlock(scrambledStartBlock)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // keystream byte = coefficient of x^15 / x^22 while repeatedly multiplying by x mod P
  task automatic ks16(output logic [7:0] ks);
    logic [16:0] t;
    for (int b = 0; b < 8; b++) begin
      ks[b[2:0]] = m16[15];
      t = {m16, 1'b0};
      if (t[16]) t = t ^ 17'h1_0039;
      m16 = t[15:0];
    end
  endtask

  task automatic ks23(output logic [7:0] ks);
    logic [23:0] t;
    for (int b = 0; b < 8; b++) begin
      ks[b[2:0]] = m23[22];
      t = {m23, 1'b0};
      if (t[23]) t = t ^ 24'hA1_0125;
      m23 = t[22:0];
    end
  endtask

  function automatic logic [7:0] first_ks23(input logic [22:0] s);
    logic [23:0] t;
    logic [7:0]  ks;
    t = {1'b0, s};
    for (int b = 0; b < 8; b++) begin
      ks[b[2:0]] = t[22];
      t = {t[22:0], 1'b0};
      if (t[23]) t = t ^ 24'hA1_0125;
    end
    return ks;
  endfunction

  task automatic model_reset();
    m16 = 16'hFFFF; m23 = seedValue[22:0]; m_cnt = 4'd0; m_type = T_DATA; m_gen = 3'd0;
  endtask

  task automatic beat(input string tag, input logic [2:0] g, input logic off, input logic [5:0] pw,
                      input logic v, input logic sb, input logic [1:0] sh,
                      input logic [31:0] d, input logic [3:0] k);
    int          n;
    logic [7:0]  by, ks, o;
    logic        trk;
    logic [31:0] ed;
    logic [3:0]  ek;
    @(negedge clk);
    GEN = g; turnOff = off; PIPEWIDTH = pw; dataValid = v; startBlock = sb;
    syncHeader = sh; data = d; dataK = k;
    n = int'(pw) / 8;
    if (n > 4) n = 4;
    ed = '0; ek = '0; trk = 1'b0;
    if (g != m_gen) begin m16 = 16'hFFFF; m23 = seedValue[22:0]; m_cnt = 4'd0; end
    m_gen = g;
    if (v) begin
      if (g == 3'd3) begin
        if (sb) begin
          m_cnt  = 4'd0;
          m_type = (sh == 2'b10) ? T_DATA : (d[7:0] == 8'hAA) ? T_SKPOS :
                   (d[7:0] == 8'h00) ? T_EIEOS : T_OTHER;
        end
        trk = sb || (m_cnt != 4'd0);
      end
      for (int i = 0; i < n; i++) begin
        by = 8'(d >> (8 * i));
        o  = by;
        if (g == 3'd1 || g == 3'd2) begin
          ek[i[1:0]] = k[i[1:0]];
          if (k[i[1:0]] && by == 8'hBC) m16 = 16'hFFFF;
          else if (!(k[i[1:0]] && by == 8'h1C)) begin
            ks16(ks);
            if (!k[i[1:0]] && !off) o = by ^ ks;
          end
        end else if (g == 3'd3 && trk && m_type != T_SKPOS) begin
          ks23(ks);
          if (m_type == T_DATA && !off) o = by ^ ks;
        end
        ed = ed | (32'(o) << (8 * i));
      end
      if (g == 3'd3 && trk) begin
        m_cnt = m_cnt + 4'(n);
        if (m_cnt == 4'd0 && m_type == T_EIEOS) m23 = seedValue[22:0];
      end
    end
    @(posedge clk); #1;
    check({tag, ".data"}, scrambledData, ed);
    check({tag, ".ctl"}, {24'd0, scrambledDataK, scrambledDataValid, scrambledSyncHeader, scrambledStartBlock},
          {24'd0, ek, v, sh, sb});
  endtask

  initial begin
    logic [5:0]  pws [3];
    logic [7:0]  g1_gold [4];
    logic [31:0] d;
    logic [3:0]  k;
    logic [1:0]  sh;
    logic [5:0]  pw;
    int          nb, typ;
    logic [2:0]  g;

    pws = '{6'd8, 6'd16, 6'd32};
    g1_gold = '{8'hFF, 8'h17, 8'hC0, 8'h14};

    reset = 1'b0; GEN = 3'd0; turnOff = 1'b0; PIPEWIDTH = 6'd8; dataValid = 1'b0;
    startBlock = 1'b0; syncHeader = 2'b00; seedValue = LANE_SEED[0]; data = '0; dataK = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset.data", scrambledData, 32'd0);
    check("reset.ctl", {27'd0, scrambledDataK, scrambledDataValid}, 32'd0);
    reset = 1'b1;

    // Gen1 byte-wide COM then zeros: FF 17 C0 14
    beat("g1w8.com", 3'd1, 1'b0, 6'd8, 1'b1, 1'b0, 2'b00, 32'h0000_00BC, 4'b0001);
    check("g1w8.com.byte", scrambledData, 32'h0000_00BC);
    for (int i = 0; i < 4; i++) begin
      beat("g1w8.d", 3'd1, 1'b0, 6'd8, 1'b1, 1'b0, 2'b00, 32'd0, 4'd0);
      check("g1w8.gold", scrambledData, {24'd0, g1_gold[i]});
    end

    // Gen1 x32: COM, SKP, then D; SKP must not advance
    beat("g1w32.a", 3'd1, 1'b0, 6'd32, 1'b1, 1'b0, 2'b00, 32'h0000_1CBC, 4'b0011);
    check("g1w32.a.gold", scrambledData, 32'h17FF_1CBC);
    beat("g1w32.b", 3'd1, 1'b0, 6'd32, 1'b1, 1'b0, 2'b00, 32'd0, 4'd0);
    check("g1w32.b.gold", scrambledData, 32'hE7B2_14C0);

    // invalid beat: zeroed, no advance
    beat("g1.inval", 3'd1, 1'b0, 6'd32, 1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF, 4'hF);

    // Gen3 data block from lane-0 seed
    seedValue = 24'h1DBFBC;
    for (int j = 0; j < 4; j++)
      beat("g3.data", 3'd3, 1'b0, 6'd32, 1'b1, j == 0, (j == 0) ? SH_DATA : 2'b00, 32'd0, 4'd0);

    // SKPOS between two data blocks
    for (int j = 0; j < 4; j++)
      beat("g3.skpos", 3'd3, 1'b0, 6'd32, 1'b1, j == 0, (j == 0) ? SH_OS : 2'b00, 32'hAAAA_AAAA, 4'd0);
    for (int j = 0; j < 4; j++)
      beat("g3.data2", 3'd3, 1'b0, 6'd32, 1'b1, j == 0, (j == 0) ? SH_DATA : 2'b00, $urandom, 4'd0);

    // EIEOS resets the LFSR to the lane seed
    for (int j = 0; j < 4; j++)
      beat("g3.eieos", 3'd3, 1'b0, 6'd32, 1'b1, j == 0, (j == 0) ? SH_OS : 2'b00, 32'hFFFF_0000, 4'd0);
    beat("g3.post_eieos", 3'd3, 1'b0, 6'd32, 1'b1, 1'b1, SH_DATA, 32'h0000_0033, 4'd0);
    check("g3.post_eieos.first", {24'd0, scrambledData[7:0]},
          {24'd0, 8'h33 ^ first_ks23(seedValue[22:0])});

    // misaligned startBlock mid-block restarts tracking
    beat("g3.mis.a", 3'd3, 1'b0, 6'd32, 1'b1, 1'b0, 2'b00, $urandom, 4'd0);
    beat("g3.mis.b", 3'd3, 1'b0, 6'd32, 1'b1, 1'b1, SH_OS, 32'h1234_561E, 4'd0);
    for (int j = 0; j < 3; j++)
      beat("g3.mis.c", 3'd3, 1'b0, 6'd32, 1'b1, 1'b0, 2'b00, $urandom, 4'd0);

    // turnOff bypass with LFSR still advancing
    beat("g1.off.com", 3'd1, 1'b0, 6'd8, 1'b1, 1'b0, 2'b00, 32'h0000_00BC, 4'b0001);
    for (int j = 0; j < 3; j++) begin
      beat("g1.off", 3'd1, 1'b1, 6'd8, 1'b1, 1'b0, 2'b00, 32'h0000_005A, 4'd0);
      check("g1.off.5a", scrambledData, 32'h0000_005A);
    end
    beat("g1.off.resume", 3'd1, 1'b0, 6'd8, 1'b1, 1'b0, 2'b00, 32'd0, 4'd0);
    check("g1.off.resume.gold", scrambledData, 32'h0000_0014);

    // randomized Gen1/Gen2 traffic
    for (int t = 0; t < 150; t++) begin
      g  = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd1;
      pw = pws[$urandom_range(0, 2)];
      d  = $urandom;
      k  = '0;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          k[i[1:0]] = 1'b1;
          case ($urandom_range(0, 2))
            0: d = (d & ~(32'hFF << (8 * i))) | (32'hBC << (8 * i));
            1: d = (d & ~(32'hFF << (8 * i))) | (32'h1C << (8 * i));
            default: ;
          endcase
        end
      end
      beat("g12.rand", g, $urandom_range(0, 9) == 0, pw, $urandom_range(0, 7) != 0,
           1'($urandom), 2'($urandom), d, k);
    end

    // randomized Gen3 blocks on a random lane seed
    seedValue = LANE_SEED[$urandom_range(0, 7)];
    for (int blk = 0; blk < 24; blk++) begin
      pw  = pws[$urandom_range(0, 2)];
      nb  = 16 / (int'(pw) / 8);
      typ = $urandom_range(0, 3);
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 7) == 0)
          beat("g3r.idle", 3'd3, 1'b0, pw, 1'b0, 1'b0, 2'b00, $urandom, 4'd0);
        d  = $urandom;
        sh = 2'b00;
        if (j == 0) begin
          case (typ)
            T_DATA:  sh = SH_DATA;
            T_SKPOS: begin sh = SH_OS; d[7:0] = SKPOS_SYM; end
            T_EIEOS: begin sh = SH_OS; d[7:0] = EIEOS_SYM; end
            default: begin sh = SH_OS; d[7:0] = 8'h1E; end
          endcase
        end
        beat("g3r", 3'd3, $urandom_range(0, 9) == 0, pw, 1'b1, j == 0, sh, d, 4'($urandom));
      end
    end

    // async reset in the middle of a beat
    beat("pre_rst", 3'd3, 1'b0, 6'd32, 1'b1, 1'b1, SH_DATA, 32'hA5A5_A5A5, 4'd0);
    @(negedge clk);
    GEN = 3'd3; dataValid = 1'b1; startBlock = 1'b0; data = $urandom;
    #2 reset = 1'b0;
    #1;
    check("async_rst.data", scrambledData, 32'd0);
    check("async_rst.ctl", {27'd0, scrambledDataK, scrambledDataValid}, 32'd0);
    check("async_rst.sb", {29'd0, scrambledSyncHeader, scrambledStartBlock}, 32'd0);
    GEN = 3'd0; dataValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int j = 0; j < 4; j++)
      beat("post_rst.g3", 3'd3, 1'b0, 6'd32, 1'b1, j == 0, (j == 0) ? SH_DATA : 2'b00, 32'd0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_lane_scrambler.md
Name: tx_lane_scrambler

Overview:
- Per-lane transmit scrambler: counterpart of the per-lane RX descrambler, sitting between TX lane striping and the PIPE TX data interface.
- One instance per lane, 16 instances in the TX top.
- Scrambles Gen1/Gen2 8b/10b symbols with the 16-bit LFSR, and Gen3 128b/130b blocks with the 23-bit lane-seeded LFSR.
- Passes K-codes, ordered-set blocks and sync headers through unscrambled, with one cycle of registered latency.

Parameters:
GEN12_SEED, 16'hFFFF, Gen1/2 LFSR value after reset and after every COM.
MAXWIDTH, 32, maximum PIPE data width in bits (4 symbols per beat).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous active-low reset.
GEN  in  3  1=Gen1, 2=Gen2, 3=Gen3.
turnOff  in  1  scrambling disable (LTSSM); data bypasses, LFSR still advances.
PIPEWIDTH  in  6  active beat width: 8, 16 or 32.
dataValid  in  1  beat qualifier.
startBlock  in  1  Gen3: beat is the first of a 128-bit block.
syncHeader  in  2  Gen3 sync header, sampled when startBlock=1.
seedValue  in  24  Gen3 lane seed; bits [22:0] used.
data  in  32  symbols, symbol 0 in [7:0], LSB-first.
dataK  in  4  K flag per symbol.
scrambledData  out  32  registered output symbols.
scrambledDataK  out  4  registered K flags.
scrambledDataValid  out  1  registered dataValid.
scrambledSyncHeader  out  2  registered syncHeader.
scrambledStartBlock  out  1  registered startBlock.

Behaviour:
- Reset (reset=0, async): all outputs 0; lfsr16=GEN12_SEED; lfsr23=seedValue[22:0]; blkType=DATA; symCnt=0.
- Latency: 1 cycle for every output. dataValid=0 beats are still registered, with data and dataK zeroed; no LFSR advance.
- Symbols per beat: n = PIPEWIDTH/8. Only symbols 0..n-1 are processed; upper symbols output 0.
- Symbols are processed serially inside the cycle, symbol 0 first; symbol i+1 sees the LFSR state left by symbol i.
- Gen1/2 per symbol:
  - K=1 and byte 8'hBC (COM): output unscrambled; LFSR := 16'hFFFF after this symbol; no advance.
  - K=1 and byte 8'h1C (SKP): output unscrambled; no advance.
  - Other K: output unscrambled; advance 8 steps.
  - D symbol: out[b] = data[b] ^ lfsr[15] before step b, for b=0..7; advance 8 steps.
  - Polynomial x^16+x^5+x^4+x^3+1, Galois form.
- Gen3 block tracking:
  - startBlock=1 and dataValid=1: symCnt := n; blkType := DATA if syncHeader=2'b10, else OS.
  - OS subtype from symbol 0: 8'hAA=SKPOS, 8'h00=EIEOS, else OTHEROS.
  - Continuation beats: symCnt += n, wrapping at 16.
  - startBlock=1 while symCnt≠0 is a misalignment: restart the block at the new beat.
- Gen3 per symbol:
  - DATA block: out[b] = data[b] ^ lfsr23[22] before step b; advance 8 steps.
  - Polynomial x^23+x^21+x^16+x^8+x^5+x^2+1.
  - OTHEROS and EIEOS: output unscrambled; advance 8 steps.
  - SKPOS: output unscrambled; no advance.
  - On the last beat of an EIEOS block (symCnt wraps to 0): lfsr23 := seedValue[22:0].
  - dataK ignored, output 0. scrambledSyncHeader mirrors syncHeader.
- turnOff=1: output equals input; LFSR update rules unchanged.
- GEN change: both LFSRs reload to seed, symCnt=0, applied on the same edge; that beat is treated as the first of the new mode.
- Reset mid-block: everything reinitialised; the next beat requires startBlock to resume Gen3 tracking.

Decomposition:
- Package tx_scrambler_pkg:
  - K-code constants: COM=8'hBC, SKP=8'h1C.
  - Gen3 constants: SKPOS=8'hAA, EIEOS=8'h00, SH_DATA=2'b10, SH_OS=2'b01.
  - Both polynomial masks, the 8 default lane seeds, and the block-type enum.
- Sub-module lfsr_byte_step (combinational): inputs lfsr state, byte, mode, enable; outputs next state and scrambled byte. Instantiated 4 times in a chain.

Test Plan:
- Gen1, PIPEWIDTH=8, COM(K) then 4 D bytes of 8'h00 -> out BC(K), FF, 17, C0, 14, one beat later.
- Gen1, PIPEWIDTH=32, beat {00,00,1C(K),BC(K)} then beat 32'h0 -> first beat out {17,FF,1C,BC}; second beat out {E7,B2,14,C0}; SKP neither scrambled nor advancing.
- Gen3, PIPEWIDTH=32, lane seed 24'h1DBFBC, sync 10, 4 beats of 0 -> out matches the golden model seeded 1DBFBC; sync 10 on the first beat only.
- Gen3, SKPOS block (AA..., sync 01) between two data blocks -> SKPOS unchanged; data after equals the contiguous LFSR stream as if SKPOS were absent.
- Gen3, EIEOS block (00/FF pattern) -> unscrambled; the next data block's first byte equals data ^ seed-derived first byte.
- turnOff=1 with Gen1 D bytes 8'h5A -> out 5A; after turnOff=0 the stream resumes at the LFSR offset counting the bypassed bytes. Async reset asserted mid-beat -> all outputs 0 immediately.
